// File: rtl/videocard_host_loader.sv
// Host-side job sequencer for the videocard. It streams source words into
// RAM port B, kicks the card, polls for completion, then reads a result block
// back out of RAM.
module videocard_host_loader #(
    parameter int WIDTH      = 32,
    parameter int BYTES      = 4,
    parameter int RD_LATENCY = 2,
    parameter int TIMEOUT    = 1048576
) (
    input  logic               clk,
    input  logic               reset_sink_reset,
    input  logic               start,
    input  logic [WIDTH/2-1:0] base_addr,
    input  logic [WIDTH/2-1:0] word_count,
    input  logic [WIDTH/2-1:0] rd_base,
    input  logic [WIDTH/2-1:0] rd_count,
    input  logic [WIDTH-1:0]   src_data,
    input  logic               src_valid,
    output logic               src_ready,
    output logic [WIDTH/2-1:0] address,
    output logic [WIDTH-1:0]   data_out,
    input  logic [WIDTH-1:0]   data_in,
    output logic [BYTES-1:0]   byteenable,
    output logic               write,
    output logic               read,
    output logic               interrupt_start,
    output logic               read_finish,
    input  logic [WIDTH-1:0]   data_finish,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_valid,
    output logic               busy,
    output logic               done,
    output logic               timeout_err
);

    localparam int AW = WIDTH / 2;
    localparam int PW = $clog2(TIMEOUT) + 1;

    localparam logic [AW-1:0] A_ONE = AW'(1);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [PW-1:0] P_END = PW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_KICK  = 3'd2;
    localparam logic [2:0] S_POLL  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [AW-1:0]         r_base;
    logic [AW-1:0]         r_wcount;
    logic [AW-1:0]         r_rd_base;
    logic [AW-1:0]         r_rd_count;
    logic [AW-1:0]         r_wr_idx;
    logic [AW-1:0]         r_rd_idx;
    logic [PW-1:0]         r_poll;
    logic [RD_LATENCY-1:0] r_vpipe;
    logic                  r_timeout_err;

    logic w_wr_fire;
    logic w_wr_last;
    logic w_read;
    logic w_rd_last;
    logic w_finish;
    logic w_poll_expired;
    logic w_pipe_empty;

    assign w_wr_fire      = (r_state == S_WRITE) && src_valid;
    assign w_wr_last      = w_wr_fire && (r_wr_idx == r_wcount - A_ONE);
    assign w_read         = (r_state == S_READ);
    assign w_rd_last      = (r_rd_idx == r_rd_count - A_ONE);
    assign w_finish       = |data_finish;
    assign w_poll_expired = (r_poll == P_END);
    assign w_pipe_empty   = ~|r_vpipe;

    // Next-state selection; finish is tested before the poll limit so it wins a tie.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (word_count == '0) ? S_KICK : S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_wr_last) begin
                    w_next_state = S_KICK;
                end
            end
            S_KICK: w_next_state = S_POLL;
            S_POLL: begin
                if (w_finish) begin
                    w_next_state = (r_rd_count != '0) ? S_READ : S_DONE;
                end else if (w_poll_expired) begin
                    w_next_state = S_DONE;
                end
            end
            S_READ: begin
                if (w_rd_last) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pipe_empty) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register; reset overrides everything, including a pending start.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset_sink_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Job parameters, transfer indices, poll counter and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset_sink_reset) begin
            r_base        <= '0;
            r_wcount      <= '0;
            r_rd_base     <= '0;
            r_rd_count    <= '0;
            r_wr_idx      <= '0;
            r_rd_idx      <= '0;
            r_poll        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base        <= base_addr;
                        r_wcount      <= word_count;
                        r_rd_base     <= rd_base;
                        r_rd_count    <= rd_count;
                        r_wr_idx      <= '0;
                        r_rd_idx      <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (w_wr_fire) begin
                        r_wr_idx <= r_wr_idx + A_ONE;
                    end
                end
                S_KICK: r_poll <= '0;
                S_POLL: begin
                    r_poll <= r_poll + P_ONE;
                    if (!w_finish && w_poll_expired) begin
                        r_timeout_err <= 1'b1;
                    end
                end
                S_READ: r_rd_idx <= r_rd_idx + A_ONE;
                default: ;
            endcase
        end
    end

    // Read-valid shift register: marks the cycle data_in carries a requested word.
    always_ff @(posedge clk) begin
        // NOTE: the pipeline is cleared on reset so reads in flight never surface as res_valid.
        if (reset_sink_reset) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= w_read;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_vpipe[k] <= r_vpipe[k-1];
            end
        end
    end

    assign src_ready       = (r_state == S_WRITE);
    assign write           = w_wr_fire;
    assign read            = w_read;
    assign interrupt_start = (r_state == S_KICK);
    assign read_finish     = (r_state == S_POLL);
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign timeout_err     = r_timeout_err;

    assign address    = (r_state == S_WRITE) ? r_base + r_wr_idx :
                        (r_state == S_READ)  ? r_rd_base + r_rd_idx : '0;
    assign data_out   = (r_state == S_WRITE) ? src_data : '0;
    assign byteenable = (r_state == S_WRITE) ? '1 : '0;

    assign res_valid  = r_vpipe[RD_LATENCY-1];
    assign res_data   = res_valid ? data_in : '0;

endmodule

// File: tb/tb_videocard_host_loader.sv
// Scoreboard bench for videocard_host_loader: every job pushes its expected
// bus events (with cycle spacing) before it is driven; a negedge monitor pops
// and compares each event the DUT produces.
module tb_videocard_host_loader;

    localparam int WIDTH = 32;
    localparam int BYTES = 4;
    localparam int LAT   = 2;
    localparam int TMO   = 16;

    localparam logic [3:0] EV_W = 4'd1;
    localparam logic [3:0] EV_R = 4'd2;
    localparam logic [3:0] EV_V = 4'd3;
    localparam logic [3:0] EV_K = 4'd4;
    localparam logic [3:0] EV_D = 4'd5;

    typedef struct {
        logic [63:0] val;
        int          gap;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
    } rdreq_t;

    logic        clk = 1'b0;
    logic        reset_sink_reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic [15:0] rd_base = '0;
    logic [15:0] rd_count = '0;
    logic [31:0] src_data = '0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [15:0] address;
    logic [31:0] data_out;
    logic [31:0] data_in = '0;
    logic [3:0]  byteenable;
    logic        write;
    logic        read;
    logic        interrupt_start;
    logic        read_finish;
    logic [31:0] data_finish = '0;
    logic [31:0] res_data;
    logic        res_valid;
    logic        busy;
    logic        done;
    logic        timeout_err;

    exp_t   exp_q[$];
    rdreq_t ram_q[$];
    int n_checks  = 0;
    int n_err     = 0;
    int cyc       = 0;
    int last_cyc  = 0;
    int poll_cnt  = 0;
    int rd_seen   = 0;
    int fin_after = 0;

    videocard_host_loader #(
        .WIDTH(WIDTH), .BYTES(BYTES), .RD_LATENCY(LAT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_sink_reset(reset_sink_reset), .start(start),
        .base_addr(base_addr), .word_count(word_count), .rd_base(rd_base),
        .rd_count(rd_count), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .address(address), .data_out(data_out),
        .data_in(data_in), .byteenable(byteenable), .write(write), .read(read),
        .interrupt_start(interrupt_start), .read_finish(read_finish),
        .data_finish(data_finish), .res_data(res_data), .res_valid(res_valid),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return {a ^ 16'hA5A5, a};
    endfunction

    function automatic logic [63:0] pack_ev(input logic [3:0] k, input logic [3:0] be,
                                            input logic [15:0] a, input logic [31:0] d);
        return {8'h00, k, be, a, d};
    endfunction

    task automatic push_exp(input logic [63:0] v, input int gap);
        exp_t e;
        e.val = v;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic observe(input string tag, input logic [63:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({"unexpected_", tag}, got, 64'h0);
        end else begin
            e = exp_q.pop_front();
            check(tag, got, e.val);
            if (e.gap >= 0) check({tag, "_gap"}, 64'(cyc - last_cyc), 64'(e.gap));
        end
        last_cyc = cyc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {35'h0, src_ready, write, read, interrupt_start, read_finish,
                              res_valid, busy, done, timeout_err, byteenable, address}, 64'h0);
        check({tag, "_dat"}, {data_out, res_data}, 64'h0);
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every DUT bus event is matched against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (write && read) check("wr_rd_excl", 64'h1, 64'h0);
        if (start && !busy && !reset_sink_reset) begin
            last_cyc = cyc;
            poll_cnt = 0;
            rd_seen  = 0;
        end
        if (read_finish) poll_cnt++;
        if (write) observe("wr", pack_ev(EV_W, byteenable, address, data_out));
        if (read) begin
            observe("rd", pack_ev(EV_R, 4'h0, address, 32'h0));
            ram_q.push_back('{cyc: cyc, addr: address});
            rd_seen++;
        end
        if (res_valid)       observe("res",  pack_ev(EV_V, 4'h0, 16'h0, res_data));
        if (interrupt_start) observe("kick", pack_ev(EV_K, 4'h0, 16'h0, 32'h0));
        if (done)            observe("done", pack_ev(EV_D, 4'h0, 16'h0, 32'h0));
    end

    // RAM read port model and videocard finish status.
    initial forever begin
        @(posedge clk);
        #1;
        data_finish = (poll_cnt >= fin_after) ? 32'h0000_0100 : 32'h0;
        while (ram_q.size() > 0 && ram_q[0].cyc + LAT < cyc) void'(ram_q.pop_front());
        if (ram_q.size() > 0 && ram_q[0].cyc + LAT == cyc) begin
            data_in = ram_word(ram_q[0].addr);
            void'(ram_q.pop_front());
        end else begin
            data_in = 32'hDEAD_BEEF;
        end
    end

    // Pushes the expected events of one job, then drives it. trunc >= 0 means
    // the caller resets the DUT after that many reads.
    task automatic run_job(input logic [15:0] base, input int wc, input logic [31:0] seed,
                           input int stall_at, input int stall_len,
                           input logic [15:0] rdb, input int rc, input int fin,
                           input int trunc, input bit poke);
        bit to_exp;
        int nr, vlim, prev, guard;
        to_exp = (fin >= TMO);
        for (int i = 0; i < wc; i++) begin
            push_exp(pack_ev(EV_W, 4'hF, base + 16'(i), seed + 32'(i)),
                     (i != 0 && i == stall_at) ? stall_len + 1 : 1);
        end
        push_exp(pack_ev(EV_K, 4'h0, 16'h0, 32'h0), 1);
        if (to_exp) begin
            push_exp(pack_ev(EV_D, 4'h0, 16'h0, 32'h0), TMO + 1);
        end else if (rc == 0) begin
            push_exp(pack_ev(EV_D, 4'h0, 16'h0, 32'h0), fin + 2);
        end else begin
            nr   = (trunc >= 0) ? trunc : rc;
            vlim = (trunc >= 0) ? trunc : rc + LAT;
            prev = 0;
            for (int o = 0; o < rc + LAT; o++) begin
                if (o < nr) begin
                    push_exp(pack_ev(EV_R, 4'h0, rdb + 16'(o), 32'h0), (o == 0) ? fin + 2 : o - prev);
                    prev = o;
                end
                if (o >= LAT && o < vlim) begin
                    push_exp(pack_ev(EV_V, 4'h0, 16'h0, ram_word(rdb + 16'(o - LAT))), o - prev);
                    prev = o;
                end
            end
            if (trunc < 0) push_exp(pack_ev(EV_D, 4'h0, 16'h0, 32'h0), -1);
        end

        fin_after = fin;
        step();
        base_addr  = base;
        word_count = 16'(wc);
        rd_base    = rdb;
        rd_count   = 16'(rc);
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < wc; i++) begin
            if (i == stall_at && stall_len > 0) begin
                src_valid = 1'b0;
                repeat (stall_len) step();
            end
            src_valid = 1'b1;
            src_data  = seed + 32'(i);
            guard = 0;
            while (!src_ready && guard < 50) begin
                step();
                guard++;
            end
            if (guard == 50) check("src_ready_wait", 64'h0, 64'h1);
            step();
        end
        src_valid = 1'b0;
        if (poke) begin
            step();
            base_addr  = 16'h1234;
            word_count = 16'd5;
            rd_count   = 16'd7;
            start      = 1'b1;
            step();
            start = 1'b0;
        end
        if (trunc < 0) begin
            guard = 0;
            while ((exp_q.size() != 0 || busy) && guard < 600) begin
                step();
                guard++;
            end
            check("job_complete", {63'h0, (exp_q.size() != 0 || busy)}, 64'h0);
            exp_q.delete();
            check("timeout_err", {63'h0, timeout_err}, {63'h0, to_exp});
            check("poll_cycles", 64'(poll_cnt), to_exp ? 64'(TMO) : 64'(fin + 1));
        end
    endtask

    initial begin
        int guard;
        repeat (3) step();
        check_quiet("reset_state");
        reset_sink_reset = 1'b0;
        step();

        // Three back-to-back writes, kick, immediate finish, no readback.
        run_job(16'h0100, 3, 32'hA, -1, 0, 16'h0, 0, 0, -1, 1'b0);
        // Five-cycle source stall between words 0 and 1.
        run_job(16'h0300, 3, 32'h100, 1, 5, 16'h0, 0, 2, -1, 1'b0);
        // Write address wraps at the top of the address space.
        run_job(16'hFFFF, 2, 32'h55, -1, 0, 16'h0, 0, 1, -1, 1'b0);
        // Ten idle polls, then four readback words.
        run_job(16'h0010, 1, 32'h77, -1, 0, 16'h0200, 4, 10, -1, 1'b0);
        // Finish never arrives: timeout, no reads; a start while busy is ignored.
        run_job(16'h0020, 1, 32'h88, -1, 0, 16'h0400, 4, 1000, -1, 1'b1);
        // Zero-length write goes straight to KICK; readback wraps; clears timeout_err.
        run_job(16'h0030, 0, 32'h0, -1, 0, 16'hFFFE, 3, 3, -1, 1'b0);
        // Finish on the last permitted poll cycle beats the timeout.
        run_job(16'h0040, 0, 32'h0, -1, 0, 16'h0500, 1, TMO - 1, -1, 1'b0);

        // Reset right after the second read of a four-word readback.
        run_job(16'h0050, 1, 32'h99, -1, 0, 16'h0600, 4, 1, 2, 1'b0);
        guard = 0;
        while (guard < 300) begin
            @(negedge clk);
            #2;
            if (rd_seen >= 2) break;
            guard++;
        end
        check("reads_before_reset", 64'(rd_seen), 64'd2);
        reset_sink_reset = 1'b1;
        step();
        check_quiet("in_reset");
        step();
        reset_sink_reset = 1'b0;
        repeat (8) step();
        check("leftover_events", 64'(exp_q.size()), 64'h0);
        check_quiet("after_reset");
        exp_q.delete();

        // A clean job after the aborted one.
        run_job(16'h0700, 2, 32'hC0DE, -1, 0, 16'h0800, 3, 4, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
